// File: rtl/ctap_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : ctap_cmd_engine
// Description : JTAG-driven command engine that issues one READ/WRITE request
//               at a time and captures the response or a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ctap_cmd_engine #(
    parameter int SCRATCH_W = 64,
    parameter int SEL_W     = 2,
    parameter int ADDR_W    = 40,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SCRATCH_W-1:0] jtag_ctap_data,
    input  logic                 jtag_ctap_reg_wr_en,
    input  logic [SEL_W-1:0]     jtag_ctap_reg_sel,
    output logic [SCRATCH_W-1:0] ctap_jtag_data,
    output logic                 ctap_jtag_interrupt_bit,
    output logic                 req_val,
    input  logic                 req_rdy,
    output logic                 req_wr,
    output logic [ADDR_W-1:0]    req_addr,
    output logic [63:0]          req_data,
    input  logic                 rsp_val,
    input  logic                 rsp_err,
    input  logic [63:0]          rsp_data
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    localparam logic [3:0] c_OP_READ  = 4'd1;
    localparam logic [3:0] c_OP_WRITE = 4'd2;

    localparam logic [SEL_W-1:0] c_SEL_INSTR = SEL_W'(0);
    localparam logic [SEL_W-1:0] c_SEL_ADDR  = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_SEL_DATA0 = SEL_W'(2);

    logic [1:0]         r_state;
    logic [3:0]         r_opcode;
    logic [ADDR_W-1:0]  r_addr;
    logic [63:0]        r_data0;
    logic               r_tmo;
    logic               r_rerr;
    logic               r_ovr;
    logic               r_irq;
    logic               r_req_val;
    logic               r_req_wr;
    logic [c_CNT_W-1:0] r_cnt;

    logic                 w_busy;
    logic [3:0]           w_new_op;
    logic                 w_go;
    logic [SCRATCH_W-1:0] w_rdata;

    assign w_busy   = (r_state != c_ST_IDLE);
    assign w_new_op = jtag_ctap_data[3:0];
    assign w_go     = (w_new_op == c_OP_READ) || (w_new_op == c_OP_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_opcode  <= '0;
            r_addr    <= '0;
            r_data0   <= '0;
            r_tmo     <= 1'b0;
            r_rerr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_irq     <= 1'b0;
            r_req_val <= 1'b0;
            r_req_wr  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (jtag_ctap_reg_wr_en) begin
                        case (jtag_ctap_reg_sel)
                            c_SEL_INSTR: begin
                                // Illegal opcodes are stored for readback but never launch a request.
                                r_opcode <= w_new_op;
                                r_irq    <= 1'b0;
                                r_tmo    <= 1'b0;
                                r_rerr   <= 1'b0;
                                r_ovr    <= 1'b0;
                                if (w_go) begin
                                    r_state   <= c_ST_ISSUE;
                                    r_req_val <= 1'b1;
                                    r_req_wr  <= (w_new_op == c_OP_WRITE);
                                end
                            end
                            c_SEL_ADDR:  r_addr  <= jtag_ctap_data[ADDR_W-1:0];
                            c_SEL_DATA0: r_data0 <= jtag_ctap_data[63:0];
                            default: ;
                        endcase
                    end
                end
                c_ST_ISSUE: begin
                    if (req_rdy) begin
                        r_state   <= c_ST_WAIT;
                        r_req_val <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                c_ST_WAIT: begin
                    // A response in the final counting cycle takes priority over the timeout.
                    if (rsp_val) begin
                        r_state <= c_ST_IDLE;
                        r_irq   <= 1'b1;
                        r_rerr  <= rsp_err;
                        if ((r_opcode == c_OP_READ) && !rsp_err) begin
                            r_data0 <= rsp_data;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_irq   <= 1'b1;
                        r_tmo   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_req_val <= 1'b0;
                end
            endcase

            if (jtag_ctap_reg_wr_en && w_busy) begin
                r_ovr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (jtag_ctap_reg_sel)
            c_SEL_INSTR: w_rdata = SCRATCH_W'({r_ovr, r_rerr, r_tmo, w_busy, 4'b0000, r_opcode});
            c_SEL_ADDR:  w_rdata = SCRATCH_W'(r_addr);
            c_SEL_DATA0: w_rdata = SCRATCH_W'(r_data0);
            default:     w_rdata = '0;
        endcase
    end

    assign ctap_jtag_data          = w_rdata;
    assign ctap_jtag_interrupt_bit = r_irq;
    assign req_val                 = r_req_val;
    assign req_wr                  = r_req_wr;
    assign req_addr                = r_addr;
    assign req_data                = r_data0;

endmodule
`default_nettype wire

// File: tb/tb_ctap_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctap_cmd_engine
// Description : Self-checking bench; expected requests are queued at launch
//               and compared at each observed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctap_cmd_engine;

    localparam int c_SW = 64;
    localparam int c_AW = 40;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [c_SW-1:0] jtag_ctap_data;
    logic            jtag_ctap_reg_wr_en;
    logic [1:0]      jtag_ctap_reg_sel;
    logic [c_SW-1:0] ctap_jtag_data;
    logic            ctap_jtag_interrupt_bit;
    logic            req_val;
    logic            req_rdy;
    logic            req_wr;
    logic [c_AW-1:0] req_addr;
    logic [63:0]     req_data;
    logic            rsp_val;
    logic            rsp_err;
    logic [63:0]     rsp_data;

    ctap_cmd_engine #(
        .SCRATCH_W (c_SW),
        .SEL_W     (2),
        .ADDR_W    (c_AW),
        .TIMEOUT   (8)
    ) u_dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .jtag_ctap_data          (jtag_ctap_data),
        .jtag_ctap_reg_wr_en     (jtag_ctap_reg_wr_en),
        .jtag_ctap_reg_sel       (jtag_ctap_reg_sel),
        .ctap_jtag_data          (ctap_jtag_data),
        .ctap_jtag_interrupt_bit (ctap_jtag_interrupt_bit),
        .req_val                 (req_val),
        .req_rdy                 (req_rdy),
        .req_wr                  (req_wr),
        .req_addr                (req_addr),
        .req_data                (req_data),
        .rsp_val                 (rsp_val),
        .rsp_err                 (rsp_err),
        .rsp_data                (rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            wr;
        logic [c_AW-1:0] addr;
        logic [63:0]     data;
    } req_t;

    req_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_hs     = 0;
    int   n_pushed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: sampled mid-cycle, the transfer completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && req_val && req_rdy) begin
            req_t e;
            n_hs++;
            check("hs_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("req_wr", 64'(req_wr), 64'(e.wr));
                check("req_addr", 64'(req_addr), 64'(e.addr));
                check("req_data", req_data, e.data);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_wr(input logic [1:0] sel, input logic [63:0] d);
        jtag_ctap_reg_sel   = sel;
        jtag_ctap_data      = d;
        jtag_ctap_reg_wr_en = 1'b1;
        cycle();
        jtag_ctap_reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [63:0] v);
        jtag_ctap_reg_sel = sel;
        #1;
        v = ctap_jtag_data;
    endtask

    task automatic push_req(input logic wr, input logic [c_AW-1:0] a, input logic [63:0] d);
        req_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic respond(input logic err, input logic [63:0] d);
        rsp_val  = 1'b1;
        rsp_err  = err;
        rsp_data = d;
        cycle();
        rsp_val  = 1'b0;
        rsp_err  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [c_AW-1:0] c_ADDR = 40'h12_3456_7890;

    initial begin
        logic [63:0] v;
        rst_n = 1'b0;
        jtag_ctap_data = '0;
        jtag_ctap_reg_wr_en = 1'b0;
        jtag_ctap_reg_sel = 2'd0;
        req_rdy = 1'b0;
        rsp_val = 1'b0;
        rsp_err = 1'b0;
        rsp_data = '0;
        repeat (3) cycle();
        check("rst_req_val", 64'(req_val), 64'd0);
        check("rst_irq", 64'(ctap_jtag_interrupt_bit), 64'd0);
        rd(2'd0, v); check("rst_status", v, 64'h0);
        rst_n = 1'b1;
        cycle();

        // Reserved select: writes ignored, reads zero
        jtag_wr(2'd3, '1);
        rd(2'd3, v); check("sel3_rd", v, 64'h0);
        rd(2'd1, v); check("sel3_addr", v, 64'h0);

        // READ with immediate ready and a response five cycles later
        req_rdy = 1'b1;
        jtag_wr(2'd1, 64'(c_ADDR));
        rd(2'd1, v); check("addr_rd", v, 64'(c_ADDR));
        push_req(1'b0, c_ADDR, 64'h0);
        jtag_wr(2'd0, 64'd1);
        check("rd_req_val_lat1", 64'(req_val), 64'd1);
        check("rd_req_wr", 64'(req_wr), 64'd0);
        repeat (5) cycle();
        rd(2'd0, v); check("rd_busy_status", v, 64'h101);
        respond(1'b0, 64'hDEADBEEF_CAFEF00D);
        rd(2'd2, v); check("rd_data0", v, 64'hDEADBEEF_CAFEF00D);
        rd(2'd0, v); check("rd_status", v, 64'h001);
        check("rd_irq", 64'(ctap_jtag_interrupt_bit), 64'd1);

        // WRITE with three cycles of backpressure
        req_rdy = 1'b0;
        jtag_wr(2'd2, 64'h55);
        push_req(1'b1, c_ADDR, 64'h55);
        jtag_wr(2'd0, 64'd2);
        check("wr_irq_clr", 64'(ctap_jtag_interrupt_bit), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("wr_hold_val", 64'(req_val), 64'd1);
            check("wr_hold_data", req_data, 64'h55);
            check("wr_hold_wr", 64'(req_wr), 64'd1);
            cycle();
        end
        req_rdy = 1'b1;
        check("wr_val_c4", 64'(req_val), 64'd1);
        cycle();
        check("wr_val_drop", 64'(req_val), 64'd0);
        cycle();
        respond(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_irq", 64'(ctap_jtag_interrupt_bit), 64'd1);
        rd(2'd2, v); check("wr_data0_kept", v, 64'h55);
        rd(2'd0, v); check("wr_status", v, 64'h002);

        // Timeout: handshake on the first edge, idle exactly 8 edges later
        push_req(1'b0, c_ADDR, 64'h55);
        jtag_wr(2'd0, 64'd1);
        cycle();
        repeat (7) cycle();
        rd(2'd0, v); check("tmo_still_busy", v, 64'h101);
        cycle();
        rd(2'd0, v); check("tmo_status", v, 64'h201);
        check("tmo_irq", 64'(ctap_jtag_interrupt_bit), 64'd1);
        rd(2'd2, v); check("tmo_data0", v, 64'h55);
        jtag_wr(2'd0, 64'd0);
        check("nop_irq_clr", 64'(ctap_jtag_interrupt_bit), 64'd0);
        rd(2'd0, v); check("nop_status", v, 64'h000);

        // Overrun during WAIT, then an error response
        push_req(1'b0, c_ADDR, 64'h55);
        jtag_wr(2'd0, 64'd1);
        cycle();
        jtag_wr(2'd0, 64'd2);
        rd(2'd0, v); check("ovr_status", v, 64'h901);
        respond(1'b1, 64'h999);
        rd(2'd0, v); check("rerr_status", v, 64'hC01);
        rd(2'd2, v); check("rerr_data0", v, 64'h55);

        // Illegal opcode: stored, no request, flags cleared
        jtag_wr(2'd0, 64'd7);
        check("ill_req_val", 64'(req_val), 64'd0);
        rd(2'd0, v); check("ill_status", v, 64'h007);
        cycle();
        check("ill_req_val2", 64'(req_val), 64'd0);

        // Response coinciding with the last timeout cycle
        push_req(1'b0, c_ADDR, 64'h55);
        jtag_wr(2'd0, 64'd1);
        cycle();
        repeat (7) cycle();
        respond(1'b0, 64'hA5A5_5A5A_0123_4567);
        rd(2'd0, v); check("coin_status", v, 64'h001);
        rd(2'd2, v); check("coin_data0", v, 64'hA5A5_5A5A_0123_4567);
        check("coin_irq", 64'(ctap_jtag_interrupt_bit), 64'd1);

        // Reset pulse while a request is outstanding in ISSUE
        req_rdy = 1'b0;
        jtag_wr(2'd0, 64'd2);
        check("issue_val", 64'(req_val), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_req_val", 64'(req_val), 64'd0);
        check("arst_irq", 64'(ctap_jtag_interrupt_bit), 64'd0);
        rd(2'd0, v); check("arst_status", v, 64'h0);
        rd(2'd1, v); check("arst_addr", v, 64'h0);
        rd(2'd2, v); check("arst_data0", v, 64'h0);
        cycle();
        rst_n = 1'b1;
        req_rdy = 1'b1;
        respond(1'b0, 64'h1234);
        check("post_rst_val", 64'(req_val), 64'd0);
        check("post_rst_irq", 64'(ctap_jtag_interrupt_bit), 64'd0);
        rd(2'd2, v); check("post_rst_data0", v, 64'h0);
        cycle();

        check("hs_count", 64'(n_hs), 64'(n_pushed));
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctap_cmd_engine.md
CTAP_CMD_ENGINE -- requirements
Module: ctap_cmd_engine

Interface
REQ-001 SHALL have parameter SCRATCH_W, default 64, JTAG scratch and data width.
REQ-002 SHALL have parameter SEL_W, default 2, register-select width.
REQ-003 SHALL have parameter ADDR_W, default 40, request address width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum cycles waiting for a response (minimum 2).
REQ-005 SHALL have port clk, input, 1, processor clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port jtag_ctap_data, input, SCRATCH_W, write data from the JTAG interface.
REQ-008 SHALL have port jtag_ctap_reg_wr_en, input, 1, one-cycle register write strobe.
REQ-009 SHALL have port jtag_ctap_reg_sel, input, SEL_W, register select: 0 INSTRUCTION, 1 ADDRESS, 2 DATA0, 3 reserved.
REQ-010 SHALL have port ctap_jtag_data, output, SCRATCH_W, readback of the selected register.
REQ-011 SHALL have port ctap_jtag_interrupt_bit, output, 1, command-complete flag.
REQ-012 SHALL have ports req_val (output, 1), req_rdy (input, 1), req_wr (output, 1), req_addr (output, ADDR_W) and req_data (output, 64) forming the request channel.
REQ-013 SHALL have ports rsp_val (input, 1), rsp_err (input, 1) and rsp_data (input, 64) forming the response channel, which is always accepted.

Function
REQ-014 Registers SHALL be:
- INSTR opcode[3:0]
- ADDR[ADDR_W-1:0]
- DATA0[63:0]
- status flags: busy, tmo, rerr, ovr.
REQ-015 With wr_en=1 and state IDLE, the write SHALL behave per sel:
- sel 0: loads opcode from data[3:0].
- sel 1: loads ADDR from data[ADDR_W-1:0].
- sel 2: loads DATA0 from data[63:0].
- sel 3: ignored.
REQ-016 Opcodes SHALL be 0 NOP, 1 READ, 2 WRITE; any other value SHALL be stored but treated as NOP.
REQ-017 An INSTR write SHALL clear the interrupt, tmo, rerr and ovr flags in the cycle after the write.
REQ-018 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-019 IDLE -> ISSUE SHALL occur on an INSTR write with opcode 1 or 2; req_val SHALL assert the next cycle (latency 1).
REQ-020 In ISSUE, the following SHALL hold:
- req_val=1, with req_wr/req_addr/req_data stable (req_wr=opcode==2, req_data=DATA0).
- Remain until req_val&req_rdy, then go to WAIT and clear the timeout counter.
REQ-021 In WAIT, the counter SHALL increment every cycle; rsp_val=1 SHALL return the FSM to IDLE next cycle.
REQ-022 On rsp_val in WAIT, the engine SHALL:
- Set the interrupt.
- Set rerr=rsp_err.
- For READ only with rsp_err=0, load DATA0=rsp_data.
All of these SHALL take effect in the same cycle as the return to IDLE.
REQ-023 When the counter reaches TIMEOUT-1 in WAIT with no rsp_val, the engine SHALL return to IDLE, set tmo=1, set the interrupt and leave DATA0 unchanged.
REQ-024 When rsp_val and the timeout coincide, the response SHALL win and tmo SHALL stay 0.
REQ-025 rsp_val in IDLE or ISSUE SHALL be ignored with no state change.
REQ-026 A wr_en to any sel while not IDLE SHALL be ignored and SHALL set ovr=1.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 ctap_jtag_data SHALL be combinational on sel:
- sel 0: {zeros, ovr[11], rerr[10], tmo[9], busy[8], 4'b0, opcode[3:0]}.
- sel 1: zero-extended ADDR.
- sel 2: DATA0.
- sel 3: zero.
REQ-029 A NOP or illegal opcode write SHALL leave the FSM in IDLE and SHALL NOT set the interrupt.

Reset
REQ-030 While rst_n=0, the engine SHALL immediately force:
- State IDLE.
- All registers and flags 0.
- req_val=0, req_wr=0, req_addr=0, req_data=0.
- ctap_jtag_interrupt_bit=0.
REQ-031 A reset asserted mid-ISSUE or mid-WAIT SHALL abort the command with no request retained; a response arriving after deassertion SHALL be ignored per REQ-025.
REQ-032 Reset deassertion SHALL be synchronized externally; the first active edge after deassertion SHALL accept writes.

Verification
REQ-033 Read: write ADDR=0x12_3456_7890, INSTR=1; req_rdy=1; rsp_val with rsp_data=0xDEADBEEF_CAFEF00D after 5 cycles -> req_val asserts 1 cycle after the INSTR write with req_wr=0; afterwards DATA0=0xDEADBEEFCAFEF00D, interrupt=1, status=0x001.
REQ-034 Write with backpressure: DATA0=0x55, INSTR=2, req_rdy held 0 for 3 cycles -> req_val held 4 cycles with req_data=0x55 stable; one handshake only; interrupt set on rsp_val.
REQ-035 Timeout: TIMEOUT=8, no response -> return to IDLE exactly 8 cycles after the handshake, status=0x201, DATA0 unchanged; then the next INSTR write clears the interrupt.
REQ-036 Overrun/illegal: INSTR write during WAIT -> ovr=1, opcode unchanged; INSTR=7 in IDLE -> no req_val, status=0x007.
REQ-037 Edge cases: rsp_val and timeout in the same cycle -> tmo=0 and data captured; reset pulse during ISSUE -> req_val=0 immediately, state IDLE, registers 0.
